// File: rtl/hazard_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : hazard_scoreboard                                                 |
// | Desc   : In-flight rd tracking for EX/MEM/WB plus load-use / load-wait     |
// |          stall and bubble generation for a 5-stage RISC-V pipeline.        |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module hazard_scoreboard #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             flush,
    input  logic             mem_ready,
    output logic [4:0]       id_ex_rd,
    output logic             id_ex_regwrite,
    output logic [4:0]       ex_mem_rd,
    output logic             ex_mem_regwrite,
    output logic [4:0]       mem_wb_rd,
    output logic             mem_wb_regwrite,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             bubble_ex,
    output logic             mem_timeout_err,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] C_TIMEOUT = WAIT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0]  C_CNT_MAX = '1;

    typedef enum logic [0:0] {
        S_RUN      = 1'b0,
        S_MEM_WAIT = 1'b1
    } state_t;

    state_t            r_state;

    logic              r_ide_valid;
    logic [4:0]        r_ide_rd;
    logic              r_ide_regwrite;
    logic              r_ide_memread;
    logic              r_exm_valid;
    logic [4:0]        r_exm_rd;
    logic              r_exm_regwrite;
    logic              r_exm_memread;
    logic              r_mwb_valid;
    logic [4:0]        r_mwb_rd;
    logic              r_mwb_regwrite;

    logic [WAIT_W-1:0] r_wait_cnt;
    logic [WAIT_W-1:0] w_wait_next;
    logic              r_err;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic              w_load_use;
    logic              w_mem_wait;
    logic              w_stall_id;
    logic              w_stall_ex;
    logic              w_bubble_ex;

    always_comb begin
        w_load_use = r_ide_valid && r_ide_memread && r_ide_regwrite &&
                     (r_ide_rd != 5'd0) && id_valid &&
                     ((id_uses_rs1 && (r_ide_rd == id_rs1)) ||
                      (id_uses_rs2 && (r_ide_rd == id_rs2)));
        w_mem_wait = r_exm_valid && r_exm_memread && !mem_ready;

        // Load wait outranks flush, which outranks a load-use stall.
        w_stall_ex  = !reset && w_mem_wait;
        w_stall_id  = !reset && (w_mem_wait || (w_load_use && !flush));
        w_bubble_ex = !reset && !w_mem_wait && (w_load_use || flush);
    end

    // In RUN the first wait cycle restarts the run length at one.
    always_comb begin
        if (r_state == S_RUN) begin
            w_wait_next = WAIT_W'(1);
        end else if (r_wait_cnt == C_TIMEOUT) begin
            w_wait_next = r_wait_cnt;
        end else begin
            w_wait_next = r_wait_cnt + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_RUN;
            r_ide_valid    <= 1'b0;
            r_ide_rd       <= 5'd0;
            r_ide_regwrite <= 1'b0;
            r_ide_memread  <= 1'b0;
            r_exm_valid    <= 1'b0;
            r_exm_rd       <= 5'd0;
            r_exm_regwrite <= 1'b0;
            r_exm_memread  <= 1'b0;
            r_mwb_valid    <= 1'b0;
            r_mwb_rd       <= 5'd0;
            r_mwb_regwrite <= 1'b0;
            r_wait_cnt     <= '0;
            r_err          <= 1'b0;
            r_stall_cnt    <= '0;
        end else begin
            if (w_mem_wait) begin
                r_state     <= S_MEM_WAIT;
                r_ide_valid <= r_ide_valid && !flush;
                r_mwb_valid <= 1'b0;
                r_wait_cnt  <= w_wait_next;
                if (w_wait_next >= C_TIMEOUT) begin
                    r_err <= 1'b1;
                end
            end else begin
                r_state        <= S_RUN;
                r_ide_valid    <= id_valid && !flush && !w_load_use;
                r_ide_rd       <= id_rd;
                r_ide_regwrite <= id_regwrite;
                r_ide_memread  <= id_memread;
                r_exm_valid    <= r_ide_valid;
                r_exm_rd       <= r_ide_rd;
                r_exm_regwrite <= r_ide_regwrite;
                r_exm_memread  <= r_ide_memread;
                r_mwb_valid    <= r_exm_valid;
                r_mwb_rd       <= r_exm_rd;
                r_mwb_regwrite <= r_exm_regwrite;
                r_wait_cnt     <= '0;
            end
            if (w_stall_id && (r_stall_cnt != C_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign id_ex_rd        = r_ide_valid ? r_ide_rd : 5'd0;
    assign id_ex_regwrite  = r_ide_valid && r_ide_regwrite;
    assign ex_mem_rd       = r_exm_valid ? r_exm_rd : 5'd0;
    assign ex_mem_regwrite = r_exm_valid && r_exm_regwrite;
    assign mem_wb_rd       = r_mwb_valid ? r_mwb_rd : 5'd0;
    assign mem_wb_regwrite = r_mwb_valid && r_mwb_regwrite;
    assign stall_id        = w_stall_id;
    assign stall_ex        = w_stall_ex;
    assign bubble_ex       = w_bubble_ex;
    assign mem_timeout_err = r_err;
    assign stall_cycles    = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_hazard_scoreboard                                              |
// | Desc   : Directed and random stimulus against a queue-style pipeline model.|
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_hazard_scoreboard;

    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = 6;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             id_valid = 1'b0;
    logic [4:0]       id_rs1 = 5'd0;
    logic [4:0]       id_rs2 = 5'd0;
    logic             id_uses_rs1 = 1'b0;
    logic             id_uses_rs2 = 1'b0;
    logic [4:0]       id_rd = 5'd0;
    logic             id_regwrite = 1'b0;
    logic             id_memread = 1'b0;
    logic             flush = 1'b0;
    logic             mem_ready = 1'b1;
    logic [4:0]       id_ex_rd;
    logic             id_ex_regwrite;
    logic [4:0]       ex_mem_rd;
    logic             ex_mem_regwrite;
    logic [4:0]       mem_wb_rd;
    logic             mem_wb_regwrite;
    logic             stall_id;
    logic             stall_ex;
    logic             bubble_ex;
    logic             mem_timeout_err;
    logic [CNT_W-1:0] stall_cycles;

    hazard_scoreboard #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .flush(flush), .mem_ready(mem_ready),
        .id_ex_rd(id_ex_rd), .id_ex_regwrite(id_ex_regwrite),
        .ex_mem_rd(ex_mem_rd), .ex_mem_regwrite(ex_mem_regwrite),
        .mem_wb_rd(mem_wb_rd), .mem_wb_regwrite(mem_wb_regwrite),
        .stall_id(stall_id), .stall_ex(stall_ex), .bubble_ex(bubble_ex),
        .mem_timeout_err(mem_timeout_err), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    // Model: pipe[0]=ID/EX, pipe[1]=EX/MEM, pipe[2]=MEM/WB
    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit       rw;
        bit       mr;
    } ent_t;

    ent_t pipe [3];
    int   wait_run = 0;
    bit   m_err = 0;
    int   m_cnt = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic fl,
                        input logic rdy, input logic rst_i);
        bit m_mw, m_lu, e_sid, e_sex, e_bub;
        @(negedge clk);
        id_valid = v; id_rs1 = r1; id_rs2 = r2; id_uses_rs1 = u1; id_uses_rs2 = u2;
        id_rd = rd; id_regwrite = rw; id_memread = mr; flush = fl;
        mem_ready = rdy; reset = rst_i;
        #1;
        m_mw = pipe[1].v && pipe[1].mr && !rdy;
        m_lu = pipe[0].v && pipe[0].mr && pipe[0].rw && (pipe[0].rd != 0) && v &&
               ((u1 && pipe[0].rd == r1) || (u2 && pipe[0].rd == r2));
        e_sid = !rst_i && (m_mw || (m_lu && !fl));
        e_sex = !rst_i && m_mw;
        e_bub = !rst_i && !m_mw && (m_lu || fl);
        check_val("stall_id", stall_id, e_sid);
        check_val("stall_ex", stall_ex, e_sex);
        check_val("bubble_ex", bubble_ex, e_bub);
        @(posedge clk);
        if (rst_i) begin
            for (int i = 0; i < 3; i++) pipe[i] = '{v: 0, rd: 0, rw: 0, mr: 0};
            m_err = 0; m_cnt = 0; wait_run = 0;
        end else begin
            if (m_mw) begin
                pipe[2].v = 0;
                pipe[0].v = pipe[0].v && !fl;
                wait_run++;
                if (wait_run >= MEM_TIMEOUT) m_err = 1;
            end else begin
                pipe[2] = pipe[1];
                pipe[1] = pipe[0];
                pipe[0] = '{v: v && !fl && !m_lu, rd: rd, rw: rw, mr: mr};
                wait_run = 0;
            end
            if (e_sid && m_cnt < CNT_MAX) m_cnt++;
        end
        #1;
        check_val("id_ex_rd", id_ex_rd, pipe[0].v ? pipe[0].rd : 5'd0);
        check_val("id_ex_regwrite", id_ex_regwrite, pipe[0].v && pipe[0].rw);
        check_val("ex_mem_rd", ex_mem_rd, pipe[1].v ? pipe[1].rd : 5'd0);
        check_val("ex_mem_regwrite", ex_mem_regwrite, pipe[1].v && pipe[1].rw);
        check_val("mem_wb_rd", mem_wb_rd, pipe[2].v ? pipe[2].rd : 5'd0);
        check_val("mem_wb_regwrite", mem_wb_regwrite, pipe[2].v && pipe[2].rw);
        check_val("mem_timeout_err", mem_timeout_err, m_err);
        check_val("stall_cycles", stall_cycles, m_cnt);
    endtask

    // Shorthands: load, ALU op, bubble cycle
    task automatic lw(input logic [4:0] rd, input logic rdy);
        step(1, 0, 0, 1, 0, rd, 1, 1, 0, rdy, 0);
    endtask

    task automatic alu(input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                       input logic u2, input logic fl);
        step(1, r1, r2, 1, u2, rd, 1, 0, fl, 1, 0);
    endtask

    task automatic nop(input logic rdy);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, rdy, 0);
    endtask

    task automatic rst_cycle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) pipe[i] = '{v: 0, rd: 0, rw: 0, mr: 0};
        rst_cycle();
        rst_cycle();
        check_val("reset_stall_cycles", stall_cycles, 0);

        // lw x5 ; add x6,x5,x7 (stalls once, then re-issued)
        lw(5, 1);
        alu(6, 5, 7, 1, 0);
        check_val("lu_id_ex_rd", id_ex_rd, 0);
        check_val("lu_ex_mem_rd", ex_mem_rd, 5);
        alu(6, 5, 7, 1, 0);
        check_val("lu_add_issued", id_ex_rd, 6);
        check_val("lu_stall_count", stall_cycles, 1);

        // No hazard: rs2 match with uses_rs2=0, and load of x0
        lw(5, 1);
        alu(6, 0, 5, 0, 0);
        lw(0, 1);
        alu(7, 0, 0, 1, 0);
        nop(1); nop(1);

        // Load waits three cycles in MEM
        lw(9, 1);
        nop(1);
        for (int i = 0; i < 3; i++) nop(0);
        check_val("wait_ex_mem_rd_held", ex_mem_rd, 9);
        check_val("wait_mem_wb_regwrite", mem_wb_regwrite, 0);
        nop(1);
        check_val("wait_resumed_mem_wb_rd", mem_wb_rd, 9);

        // Timeout: mem_ready low for 20 cycles
        lw(10, 1);
        nop(1);
        for (int i = 0; i < 20; i++) nop(0);
        nop(1); nop(1);
        check_val("timeout_sticky", mem_timeout_err, 1);
        rst_cycle();
        check_val("timeout_cleared", mem_timeout_err, 0);

        // flush coinciding with load-use
        lw(5, 1);
        alu(6, 5, 0, 0, 1);
        check_val("flush_lu_regwrite", id_ex_regwrite, 0);

        // Back-to-back writers, then reset mid-stream
        alu(3, 1, 2, 1, 0);
        alu(4, 1, 2, 1, 0);
        alu(5, 1, 2, 1, 0);
        check_val("b2b_mem_wb_rd", mem_wb_rd, 3);
        check_val("b2b_ex_mem_rd", ex_mem_rd, 4);
        alu(8, 1, 2, 1, 0);
        rst_cycle();
        check_val("midrst_mem_wb_rd", mem_wb_rd, 0);

        // Random traffic with small register set to provoke hazards
        for (int n = 0; n < 1500; n++) begin
            step($urandom_range(0, 3) != 0,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 2) == 0), $urandom_range(0, 7) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 299) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
